// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM states
// and the alignment rule used when DMEM_MISALIGN_TRAP_EN is defined.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load path: selects the byte/half lane from a stored word and
// sign- or zero-extends it; word loads pass through untouched.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses via rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output state_e      dbg_state
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wen_q, wen_d;
    logic [1:0]    size_q, size_d;
    logic          sign_q, sign_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   rd_word, load_data, wr_bytes;
    logic [3:0]    wr_mask;
    logic          misaligned, enter_resp, commit;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign idx     = addr_q[AW+1:2];
    assign rd_word = mem_q[idx];

    dmem_load_align u_align (
        .word_i (rd_word),
        .lane_i (addr_q[1:0]),
        .size_i (size_q),
        .sign_i (sign_q),
        .data_o (load_data)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(size_q, addr_q[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign enter_resp = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign commit     = enter_resp && wen_q && !misaligned && !rst;

    always_comb begin
        wr_mask  = 4'b1111;
        wr_bytes = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                wr_mask  = 4'b0001 << addr_q[1:0];
                wr_bytes = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                wr_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_bytes = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // the responder holds rsp_* stable from rsp_valid rising until that edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    size_d  = req_size;
                    sign_d  = req_sign;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    err_d   = misaligned;
                    rdata_d = (wen_q || misaligned) ? 32'd0 : load_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is never cleared by reset; only the commit strobe is gated by it.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem_q[idx][8*b +: 8] <= wr_bytes[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid & err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to rsp_valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_wen  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port req_sign  input  1  load sign-extend (1) or zero-extend (0).
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-014 SHALL have port rsp_rdata  output  32  load data, aligned and extended; 0 for stores.
REQ-015 SHALL have port rsp_err  output  1  misaligned-access error (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; one request outstanding at most.
REQ-017 SHALL assert req_ready only in IDLE; accept on req_valid && req_ready, latching all req_* fields.
REQ-018 SHALL on accept load a down-counter with LATENCY-1 and enter WAIT; LATENCY=1 goes directly to RESP on the following edge.
REQ-019 SHALL leave WAIT for RESP on the edge where counter equals 0; rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 SHALL commit stores and sample load data on the edge entering RESP.
REQ-021 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready; return to IDLE on that edge (no same-cycle new accept).
REQ-022 SHALL index word = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap).
REQ-023 SHALL write byte wdata[7:0] into lane addr[1:0]; half wdata[15:0] into half addr[1]; word all lanes; other lanes unchanged.
REQ-024 SHALL extract load byte/half by same lane rules and extend per latched req_sign; word unextended.
REQ-025 SHALL drive rsp_rdata = 0 and rsp_err = 0 whenever rsp_valid = 0.

Reset
REQ-026 SHALL on rst force IDLE, counter 0, req_ready=1 next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 SHALL discard an in-flight request on rst mid-WAIT (store not committed); storage contents not cleared.
REQ-028 SHALL give rst priority over every simultaneous event.

Configuration
REQ-029 SHALL use macro DMEM_MISALIGN_TRAP_EN.
REQ-030 SHALL with macro defined flag half with addr[0]=1 or word with addr[1:0]!=0 as misaligned: no store commit, rsp_rdata=0, rsp_err=1.
REQ-031 SHALL without macro tie rsp_err to 0; half ignores addr[0], word ignores addr[1:0].

Structure
REQ-032 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state enum in shared package dmem_pkg.
REQ-033 SHALL isolate load lane extraction/extension in combinational sub-module dmem_load_align; storage array inline.

Verification
REQ-034 SHALL cover: store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
REQ-035 SHALL cover: store byte 0x80 @0x13, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
REQ-036 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout.
REQ-037 SHALL cover: store word 0x12345678 @0x10, rst asserted mid-WAIT -> load @0x10 returns 0x80ADBEEF.
REQ-038 SHALL cover: with DMEM_MISALIGN_TRAP_EN, store half @0x11 -> rsp_err=1, word unchanged; without macro -> half written at lanes 0-1.
REQ-039 SHALL cover: DEPTH_WORDS=1024, store @0x1000 then load @0x0 -> same data (wrap).
